// File: rtl/vector_cache_pkg.sv
// -----------------------------------------------------------------------------
// vector_cache_pkg
//   Shared types and constants for the vector cache request/response fabric.
//   - TXNID_WIDTH   : width of the transaction id carried by every response
//   - WB_REQ_NUM    : number of write-back request masters
//   - WW_REQ_NUM    : number of write-through request masters
//   - wr_resp_pld_t : write-response payload (txnid, response code, user bits)
// -----------------------------------------------------------------------------
package vector_cache_pkg;

    localparam int TXNID_WIDTH = 8;
    localparam int WB_REQ_NUM  = 4;
    localparam int WW_REQ_NUM  = 4;

    typedef struct packed {
        logic [TXNID_WIDTH-1:0] txnid;
        logic [1:0]             resp;
        logic [7:0]             user;
    } wr_resp_pld_t;

endpackage

// File: rtl/wr_resp_route_xbar_rr_arb.sv
// -----------------------------------------------------------------------------
// vc_rr_arb
//   Round-robin arbiter with an internal rotating priority pointer.
//   Ports:
//     clk, rst : clock, synchronous active-high reset (pointer -> 0)
//     req      : request vector, N bits
//     en       : grant enable; gnt is forced to zero while en is low
//     gnt      : one-hot grant, N bits
//     gnt_idx  : index of the winning request (valid when |req)
//   The pointer moves to gnt_idx+1 (wrapping at N) only when en && |req.
// -----------------------------------------------------------------------------
module vc_rr_arb #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] ptr;
    logic [N-1:0]  pick;
    int            idx;

    // Scan from the farthest position back toward ptr so the request closest
    // to ptr (in wrap-around order) is the last one written and wins.
    always_comb begin
        pick    = '0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                pick      = '0;
                pick[idx] = 1'b1;
                gnt_idx   = IW'(idx);
            end
        end
    end

    assign gnt = en ? pick : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en && (|req)) begin
            ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/wr_resp_route_xbar.sv
// -----------------------------------------------------------------------------
// wr_resp_route_xbar
//   Routes write responses from IN_NUM sources to OUT_NUM masters. The target
//   master id is txnid[SEL_LSB +: $clog2(OUT_NUM)]. Each source feeds a small
//   FIFO; each output has a round-robin arbiter and a registered output stage.
//   Ports:
//     clk, rst          : clock, synchronous active-high reset
//     in_vld/in_rdy     : per-source handshake (in_rdy = FIFO not full)
//     in_pld            : per-source payload
//     out_vld/out_rdy   : per-master handshake
//     out_pld           : per-master registered payload
//     err_vld, err_src  : one-cycle pulse + lowest source index when a response
//                         with an out-of-range master id was dropped
//   Build option:
//     WR_RESP_ROUTE_CHK_EN : drop heads whose id >= OUT_NUM and report them on
//                            err_vld/err_src. Without it the id is trusted
//                            (OUT_NUM must be a power of two) and err_* are 0.
//   FIFO_DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module wr_resp_route_xbar
    import vector_cache_pkg::*;
#(
    parameter int IN_NUM     = 8,
    parameter int OUT_NUM    = 4,
    parameter int SEL_LSB    = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IN_NUM-1:0]         in_vld,
    output logic [IN_NUM-1:0]         in_rdy,
    input  wr_resp_pld_t              in_pld  [IN_NUM],
    output logic [OUT_NUM-1:0]        out_vld,
    input  logic [OUT_NUM-1:0]        out_rdy,
    output wr_resp_pld_t              out_pld [OUT_NUM],
    output logic                      err_vld,
    output logic [$clog2(IN_NUM)-1:0] err_src
);

    localparam int IW = $clog2(IN_NUM);
    localparam int OW = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    wr_resp_pld_t       mem  [IN_NUM][FIFO_DEPTH];
    logic [AW-1:0]      wptr [IN_NUM];
    logic [AW-1:0]      rptr [IN_NUM];
    logic [AW:0]        cnt  [IN_NUM];

    logic [IN_NUM-1:0]  push;
    logic [IN_NUM-1:0]  pop;
    logic [IN_NUM-1:0]  illegal;
    logic [IN_NUM-1:0]  head_vld_p0;
    wr_resp_pld_t       head_pld_p0 [IN_NUM];
    logic [OW-1:0]      sel_p0      [IN_NUM];

    logic [IN_NUM-1:0]  req     [OUT_NUM];
    logic [IN_NUM-1:0]  gnt     [OUT_NUM];
    logic [IW-1:0]      gnt_idx [OUT_NUM];
    logic [OUT_NUM-1:0] out_en;

    // ---- stage p0: FIFO heads, decode, arbitration ----
    always_comb begin
        for (int i = 0; i < IN_NUM; i++) begin
            in_rdy[i]      = (cnt[i] != (AW+1)'(FIFO_DEPTH));
            head_vld_p0[i] = (cnt[i] != '0);
            head_pld_p0[i] = mem[i][rptr[i]];
            sel_p0[i]      = head_pld_p0[i].txnid[SEL_LSB +: OW];
        end
    end

    assign push = in_vld & in_rdy;

    always_comb begin
        for (int j = 0; j < OUT_NUM; j++) begin
            out_en[j] = !out_vld[j] || out_rdy[j];
            for (int i = 0; i < IN_NUM; i++) begin
                req[j][i] = head_vld_p0[i] && (int'(sel_p0[i]) == j);
            end
        end
    end

    for (genvar j = 0; j < OUT_NUM; j++) begin : g_arb
        vc_rr_arb #(.N(IN_NUM)) u_arb (
            .clk     (clk),
            .rst     (rst),
            .req     (req[j]),
            .en      (out_en[j]),
            .gnt     (gnt[j]),
            .gnt_idx (gnt_idx[j])
        );
    end

`ifdef WR_RESP_ROUTE_CHK_EN
    logic [IW-1:0] err_idx;

    always_comb begin
        for (int i = 0; i < IN_NUM; i++) begin
            illegal[i] = head_vld_p0[i] && (int'(sel_p0[i]) >= OUT_NUM);
        end
    end

    always_comb begin
        err_idx = '0;
        for (int i = IN_NUM - 1; i >= 0; i--) begin
            if (illegal[i]) err_idx = IW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_vld <= 1'b0;
            err_src <= '0;
        end else begin
            err_vld <= |illegal;
            if (|illegal) err_src <= err_idx;
        end
    end
`else
    assign illegal = '0;
    assign err_vld = 1'b0;
    assign err_src = '0;
`endif

    // A head decodes to one output at most, so OR-ing the grants never
    // produces two pops of the same FIFO.
    always_comb begin
        pop = illegal;
        for (int j = 0; j < OUT_NUM; j++) begin
            pop = pop | gnt[j];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < IN_NUM; i++) begin
                cnt[i]  <= '0;
                wptr[i] <= '0;
                rptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < IN_NUM; i++) begin
                if (push[i]) wptr[i] <= wptr[i] + 1'b1;
                if (pop[i])  rptr[i] <= rptr[i] + 1'b1;
                case ({push[i], pop[i]})
                    2'b10:   cnt[i] <= cnt[i] + 1'b1;
                    2'b01:   cnt[i] <= cnt[i] - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Storage is written at wptr and read at rptr, so a push into an empty
    // FIFO only becomes the head in the following cycle (no bypass).
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_NUM; i++) begin
            if (push[i]) mem[i][wptr[i]] <= in_pld[i];
        end
    end

    // ---- stage p1: registered outputs ----
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < OUT_NUM; j++) begin
                out_vld[j] <= 1'b0;
                out_pld[j] <= '0;
            end
        end else begin
            for (int j = 0; j < OUT_NUM; j++) begin
                if (|gnt[j]) begin
                    out_vld[j] <= 1'b1;
                    out_pld[j] <= head_pld_p0[gnt_idx[j]];
                end else if (out_rdy[j]) begin
                    out_vld[j] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_wr_resp_route_xbar.sv
module tb_wr_resp_route_xbar;
    import vector_cache_pkg::*;

    localparam int IN_NUM     = 8;
`ifdef WR_RESP_ROUTE_CHK_EN
    localparam int OUT_NUM    = 3;
`else
    localparam int OUT_NUM    = 4;
`endif
    localparam int SEL_LSB    = 2;
    localparam int FIFO_DEPTH = 2;
    localparam int IW         = $clog2(IN_NUM);
    localparam int OW         = $clog2(OUT_NUM);

    logic               clk = 1'b0;
    logic               rst;
    logic [IN_NUM-1:0]  in_vld;
    logic [IN_NUM-1:0]  in_rdy;
    wr_resp_pld_t       in_pld  [IN_NUM];
    logic [OUT_NUM-1:0] out_vld;
    logic [OUT_NUM-1:0] out_rdy;
    wr_resp_pld_t       out_pld [OUT_NUM];
    logic               err_vld;
    logic [IW-1:0]      err_src;

    wr_resp_route_xbar #(
        .IN_NUM(IN_NUM), .OUT_NUM(OUT_NUM), .SEL_LSB(SEL_LSB), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_pld(in_pld),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_pld(out_pld),
        .err_vld(err_vld), .err_src(err_src)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Each source is a queue of accepted responses; each output holds the
    // response it currently presents; each output remembers the source after
    // its last winner as the first source to consider next.
    wr_resp_pld_t q [IN_NUM][$];
    bit           exp_vld [OUT_NUM];
    wr_resp_pld_t exp_pld [OUT_NUM];
    int           rr_ptr  [OUT_NUM];
    bit           exp_err;
    logic [IW-1:0] exp_err_src;
    int           n_acc, n_deliv, n_drop;
    bit           model_on = 1'b0;

    function automatic int sel_of(input wr_resp_pld_t p);
        return (int'(p.txnid) >> SEL_LSB) % (1 << OW);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < IN_NUM; s++) q[s].delete();
        for (int j = 0; j < OUT_NUM; j++) begin
            exp_vld[j] = 1'b0;
            exp_pld[j] = '0;
            rr_ptr[j]  = 0;
        end
        exp_err     = 1'b0;
        exp_err_src = '0;
        n_acc = 0; n_deliv = 0; n_drop = 0;
    endtask

    task automatic model_step();
        bit popm [IN_NUM];
        bit err_now;
        bit push_ok;
        int g, s;
        for (int i = 0; i < IN_NUM; i++) popm[i] = 1'b0;
        for (int j = 0; j < OUT_NUM; j++) begin
            if (exp_vld[j] && out_rdy[j]) n_deliv++;
            g = -1;
            if (!exp_vld[j] || out_rdy[j]) begin
                for (int k = 0; k < IN_NUM; k++) begin
                    s = (rr_ptr[j] + k) % IN_NUM;
                    if (g < 0 && q[s].size() > 0)
                        if (sel_of(q[s][0]) == j) g = s;
                end
            end
            if (g >= 0) begin
                exp_vld[j] = 1'b1;
                exp_pld[j] = q[g][0];
                popm[g]    = 1'b1;
                rr_ptr[j]  = (g + 1) % IN_NUM;
            end else if (out_rdy[j]) begin
                exp_vld[j] = 1'b0;
            end
        end
        err_now = 1'b0;
`ifdef WR_RESP_ROUTE_CHK_EN
        for (int i = 0; i < IN_NUM; i++) begin
            if (q[i].size() > 0)
                if (sel_of(q[i][0]) >= OUT_NUM) begin
                    popm[i] = 1'b1;
                    n_drop++;
                    if (!err_now) exp_err_src = IW'(i);
                    err_now = 1'b1;
                end
        end
`endif
        exp_err = err_now;
        for (int i = 0; i < IN_NUM; i++) begin
            push_ok = in_vld[i] && (q[i].size() < FIFO_DEPTH);
            if (popm[i]) void'(q[i].pop_front());
            if (push_ok) begin
                q[i].push_back(in_pld[i]);
                n_acc++;
            end
        end
    endtask

    // Compare process: outputs of the current cycle against the model, then
    // advance the model by the upcoming clock edge.
    always @(negedge clk) begin
        if (model_on) begin
            for (int s = 0; s < IN_NUM; s++)
                check("in_rdy", 64'(in_rdy[s]), 64'(q[s].size() < FIFO_DEPTH));
            for (int j = 0; j < OUT_NUM; j++) begin
                check("out_vld", 64'(out_vld[j]), 64'(exp_vld[j]));
                check("out_pld", 64'(out_pld[j]), 64'(exp_pld[j]));
            end
            check("err_vld", 64'(err_vld), 64'(exp_err));
`ifdef WR_RESP_ROUTE_CHK_EN
            if (exp_err) check("err_src", 64'(err_src), 64'(exp_err_src));
`else
            check("err_src_tied", 64'(err_src), 64'(0));
`endif
            if (rst) model_reset();
            else     model_step();
        end
    end

    // ---------------- stimulus with literal expectations ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic single_resp();
        wr_resp_pld_t p;
        p.txnid = 8'(((OUT_NUM - 1) << SEL_LSB) | 1);   // 0x0D for 4 masters
        p.resp  = 2'b10;
        p.user  = 8'h5A;
        out_rdy   = '1;
        in_pld[3] = p;
        in_vld[3] = 1'b1;
        @(negedge clk);
        check("single_accept", 64'(in_rdy[3]), 64'(1));
        step();
        in_vld = '0;
        @(negedge clk);
        check("single_lat1", 64'(out_vld), 64'(0));
        step();
        @(negedge clk);
        check("single_vld", 64'(out_vld), 64'(1 << (OUT_NUM - 1)));
        check("single_pld", 64'(out_pld[OUT_NUM-1]), 64'(p));
        step();
        @(negedge clk);
        check("single_clr", 64'(out_vld), 64'(0));
    endtask

    task automatic contention();
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < IN_NUM; s++) begin
                in_vld[s]       = 1'b1;
                in_pld[s].txnid = 8'h04;
                in_pld[s].resp  = 2'b00;
                in_pld[s].user  = 8'(r * 8 + s);
            end
            step();
        end
        in_vld = '0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("rr_vld", 64'(out_vld[1]), 64'(1));
            check("rr_order", 64'(out_pld[1].user), 64'(k));
            step();
        end
    endtask

    task automatic backpressure();
        int  seq;
        bit  fire;
        seq        = 0;
        out_rdy[2] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            in_vld[5]       = 1'b1;
            in_pld[5].txnid = 8'h08;
            in_pld[5].resp  = 2'b01;
            in_pld[5].user  = 8'(seq);
            fire = in_rdy[5];
            step();
            if (fire) seq++;
        end
        in_vld = '0;
        check("bp_accepts", 64'(seq), 64'(3));
        check("bp_rdy_low", 64'(in_rdy[5]), 64'(0));
        out_rdy[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_vld", 64'(out_vld[2]), 64'(1));
            check("bp_order", 64'(out_pld[2].user), 64'(k));
            step();
        end
        @(negedge clk);
        check("bp_done", 64'(out_vld[2]), 64'(0));
    endtask

    task automatic parallel();
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < OUT_NUM; i++) begin
                in_vld[i]       = 1'b1;
                in_pld[i].txnid = 8'(i << SEL_LSB);
                in_pld[i].resp  = 2'b00;
                in_pld[i].user  = 8'(c);
            end
            if (c >= 2) begin
                @(negedge clk);
                check("par_vld", 64'(out_vld), 64'({OUT_NUM{1'b1}}));
                check("par_rdy", 64'(in_rdy[OUT_NUM-1:0]), 64'({OUT_NUM{1'b1}}));
            end
            step();
        end
        in_vld = '0;
        repeat (4) step();
    endtask

    task automatic reset_mid();
        out_rdy = '0;
        for (int c = 0; c < 3; c++) begin
            for (int s = 0; s < IN_NUM; s++) begin
                in_vld[s]       = 1'b1;
                in_pld[s].txnid = 8'((s % OUT_NUM) << SEL_LSB);
                in_pld[s].resp  = 2'b11;
                in_pld[s].user  = 8'($urandom);
            end
            step();
        end
        in_vld = '0;
        rst    = 1'b1;
        step();
        rst    = 1'b0;
        @(negedge clk);
        check("rst_out_vld", 64'(out_vld), 64'(0));
        check("rst_in_rdy", 64'(in_rdy), 64'({IN_NUM{1'b1}}));
        out_rdy = '1;
        step();
        single_resp();
    endtask

`ifdef WR_RESP_ROUTE_CHK_EN
    task automatic illegal_id();
        in_pld[6].txnid = 8'h0C;
        in_pld[6].resp  = 2'b00;
        in_pld[6].user  = 8'h66;
        in_vld[6]       = 1'b1;
        step();
        in_vld = '0;
        @(negedge clk);
        check("ill_err_early", 64'(err_vld), 64'(0));
        step();
        @(negedge clk);
        check("ill_err_vld", 64'(err_vld), 64'(1));
        check("ill_err_src", 64'(err_src), 64'(6));
        check("ill_no_route", 64'(out_vld), 64'(0));
        check("ill_popped", 64'(in_rdy[6]), 64'(1));
        step();
        @(negedge clk);
        check("ill_err_pulse", 64'(err_vld), 64'(0));
    endtask
`endif

    initial begin
        int total;
        rst     = 1'b1;
        in_vld  = '0;
        out_rdy = '1;
        for (int s = 0; s < IN_NUM; s++) in_pld[s] = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        model_on = 1'b1;
        @(negedge clk);
        check("reset_in_rdy", 64'(in_rdy), 64'({IN_NUM{1'b1}}));
        check("reset_out_vld", 64'(out_vld), 64'(0));
        check("reset_out_pld", 64'(out_pld[0]), 64'(0));
        step();
        rst = 1'b0;
        step();

        single_resp();
        step();
        contention();
        step();
        backpressure();
        step();
        parallel();
        reset_mid();
        step();
`ifdef WR_RESP_ROUTE_CHK_EN
        illegal_id();
        step();
`endif

        for (int c = 0; c < 3000; c++) begin
            for (int s = 0; s < IN_NUM; s++) begin
                in_vld[s]       = ($urandom_range(0, 3) != 0);
                in_pld[s].txnid = 8'($urandom);
                in_pld[s].resp  = 2'($urandom);
                in_pld[s].user  = 8'($urandom);
            end
            out_rdy = OUT_NUM'($urandom);
            step();
        end

        in_vld  = '0;
        out_rdy = '1;
        repeat (40) step();
        @(negedge clk);
        total = 0;
        for (int s = 0; s < IN_NUM; s++) total += q[s].size();
        for (int j = 0; j < OUT_NUM; j++) total += int'(exp_vld[j]);
        check("drained", 64'(total), 64'(0));
        check("conserve", 64'(n_acc), 64'(n_deliv + n_drop));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
